// File: rtl/alu_issue_stage_if.sv
// Bundles the upstream issue handshake, the ALU operand/result bus and the writeback handshake.
// master = the issue stage (drives the ALU), slave = its surroundings (upstream, ALU, writeback).
interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_res;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data;
    logic            out_we;
    logic            out_illegal;

    modport master (
        input  in_valid, in_instr, in_rs1, in_rs2, alu_res, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_rd, out_data, out_we, out_illegal
    );

    modport slave (
        output in_valid, in_instr, in_rs1, in_rs2, alu_res, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_rd, out_data, out_we, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage RV32I OP/OP-IMM/LUI issue: D register decodes and drives the combinational ALU,
// W register captures the ALU result with destination info for writeback.
module alu_issue_stage #(
    parameter int unsigned XLEN      = 32,
    parameter bit          ALLOW_LUI = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_stage_if.master   bus
);
    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111
    } opc_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_PASS_B = 4'b1001
    } alu_op_e;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_ill;
    logic            w_unused;

    logic            r_d_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_op;
    logic [4:0]      r_d_rd;
    logic            r_d_ill;

    logic            r_w_valid;
    logic [4:0]      r_out_rd;
    logic [XLEN-1:0] r_out_data;
    logic            r_out_we;
    logic            r_out_ill;

    logic            w_w_adv;
    logic            w_d_adv;
    logic            w_d_load;
    logic            w_w_load;

    assign w_opc    = bus.in_instr[6:0];
    assign w_f3     = bus.in_instr[14:12];
    assign w_f7     = bus.in_instr[31:25];
    assign w_unused = ^bus.in_instr[19:15];

    // Illegal encodings issue as ADD 0+0 so the ALU sees a benign operation.
    always_comb begin
        w_op  = ALU_ADD;
        w_a   = '0;
        w_b   = '0;
        w_ill = 1'b0;
        case (w_opc)
            OPC_OP: begin
                if (w_f7 == 7'b0000000 ||
                    (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    w_op = {w_f7[5], w_f3};
                    w_a  = bus.in_rs1;
                    w_b  = bus.in_rs2;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && w_f3 == 3'b101)) begin
                        w_op = {bus.in_instr[30], w_f3};
                        w_a  = bus.in_rs1;
                        w_b  = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
                    end else begin
                        w_ill = 1'b1;
                    end
                end else begin
                    w_op = {1'b0, w_f3};
                    w_a  = bus.in_rs1;
                    w_b  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                end
            end
            OPC_LUI: begin
                if (ALLOW_LUI) begin
                    w_op = ALU_PASS_B;
                    w_b  = {bus.in_instr[31:12], {(XLEN-20){1'b0}}};
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_w_adv  = !r_w_valid || bus.out_ready;
    assign w_d_adv  = !r_d_valid || w_w_adv;
    assign w_d_load = bus.in_valid && w_d_adv;
    assign w_w_load = r_d_valid && w_w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid  <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_d_rd     <= '0;
            r_d_ill    <= 1'b0;
            r_w_valid  <= 1'b0;
            r_out_rd   <= '0;
            r_out_data <= '0;
            r_out_we   <= 1'b0;
            r_out_ill  <= 1'b0;
        end else begin
            if (w_d_load) begin
                r_d_valid <= 1'b1;
                r_alu_a   <= w_a;
                r_alu_b   <= w_b;
                r_alu_op  <= w_op;
                r_d_rd    <= bus.in_instr[11:7];
                r_d_ill   <= w_ill;
            end else if (w_w_adv) begin
                r_d_valid <= 1'b0;
            end

            if (w_w_load) begin
                r_w_valid  <= 1'b1;
                r_out_rd   <= r_d_rd;
                r_out_data <= r_d_ill ? '0 : bus.alu_res;
                r_out_we   <= !r_d_ill && (r_d_rd != 5'd0);
                r_out_ill  <= r_d_ill;
            end else if (bus.out_ready) begin
                r_w_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_d_adv;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.out_valid   = r_w_valid;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_data    = r_out_data;
    assign bus.out_we      = r_out_we;
    assign bus.out_illegal = r_out_ill;
endmodule
